wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 23, width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 8, width of all data ports.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, watchdog limit in cycles; used only with WB_ARBITER_TIMEOUT_EN; legal range 1..65535.
REQ-004 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 wbmN_cyc_i, wbmN_stb_i, wbmN_we_i (N=0,1)  input  1 each  master N Wishbone classic cycle, strobe and write enable.
REQ-007 wbmN_adr_i  input  ADDR_WIDTH  master N address.
REQ-008 wbmN_dat_i  input  DATA_WIDTH  master N write data.
REQ-009 wbmN_ack_o, wbmN_err_o, wbmN_rty_o  output  1 each  master N responses.
REQ-010 wbmN_dat_o  output  DATA_WIDTH  master N read data.
REQ-011 wbs_cyc_o, wbs_stb_o, wbs_we_o  output  1 each  shared slave cycle, strobe and write enable.
REQ-012 wbs_adr_o  output  ADDR_WIDTH; wbs_dat_o  output  DATA_WIDTH  shared slave address and write data.
REQ-013 wbs_ack_i, wbs_err_i, wbs_rty_i  input  1 each  slave responses.
REQ-014 wbs_dat_i  input  DATA_WIDTH  slave read data.
REQ-015 grant_o  output  2  one-hot current owner; 2'b00 when idle.

Function
REQ-016 FSM states: IDLE, BUSY; the owner index and the last-served pointer last_q are registers.
REQ-017 In IDLE with any wbmN_cyc_i high, the arbiter registers a grant and enters BUSY on the next edge, giving 1 cycle of arbitration latency.
REQ-018 If both requests are high in IDLE, the master other than last_q wins (round-robin); a single requester always wins.
REQ-019 In BUSY, wbs_cyc_o/stb_o/we_o/adr_o/dat_o are combinationally muxed from the owner, and wbs_cyc_o/stb_o are gated by the owner's cyc_i in the same cycle.
REQ-020 In BUSY, the owner receives wbs_ack_i/err_i/rty_i/dat_i combinationally, giving zero added response latency.
REQ-021 The non-owner always sees ack/err/rty=0 and dat_o=0; its requests are held off, never dropped.
REQ-022 The owner keeps the bus for any number of strobes until its cyc_i is low at an edge; at that edge the arbiter sets last_q to the owner, clears grant_o and enters IDLE.
REQ-023 At least one IDLE cycle separates consecutive grants; no same-edge handover.
REQ-024 In IDLE, all wbs_* outputs are 0 and all master responses are 0.
REQ-025 A slave response arriving while wbs_cyc_o=0 is ignored and not forwarded.

Reset
REQ-026 rst_ni low shall immediately force IDLE, grant_o=0, last_q=1 (master 0 wins the first tie), all wbs_* and wbmN_* outputs 0, and the watchdog counter 0, including mid-transfer.
REQ-027 After rst_ni rises, the first grant shall occur no earlier than the second rising clk_i edge.

Configuration
REQ-028 Macro WB_ARBITER_TIMEOUT_EN defined: a 16-bit counter increments each BUSY cycle with wbs_stb_o=1 and no ack/err/rty, and clears on any response or state change.
REQ-029 With WB_ARBITER_TIMEOUT_EN, when the counter equals TIMEOUT_CYCLES the owner receives wbmN_err_o=1 for exactly one cycle with wbs_stb_o forced 0, the counter clears, and the FSM stays in BUSY.
REQ-030 Macro undefined: no counter is instantiated, TIMEOUT_CYCLES is ignored, and err reaches a master only from wbs_err_i.

Structure
REQ-031 Shared package wb_pkg holds the arb_state_t enum (IDLE, BUSY) and the default ADDR_WIDTH/DATA_WIDTH constants.
REQ-032 The watchdog is a sub-module wb_arb_timeout (counter plus compare), instantiated only under WB_ARBITER_TIMEOUT_EN.

Verification
REQ-033 Single master: m0 reads 0x000010, slave acks with 0xA5 after 3 cycles -> grant_o=01 one cycle after cyc, wbm0_dat_o=0xA5 with ack, wbm1_ack_o stays 0.
REQ-034 Simultaneous request after reset: both cyc high -> m0 granted first; m0 drops cyc -> one IDLE cycle, then grant_o=10; next tie -> m0 granted.
REQ-035 Bus lock: m1 holds cyc across 4 strobes while m0 requests -> grant_o stays 10 for all 4 acks, and m0 is granted only after m1 drops cyc.
REQ-036 Reset mid-transfer: rst_ni low while m1 owns the bus with stb high -> all outputs 0 in the same cycle; after release a tie grants m0.
REQ-037 Timeout (macro defined, TIMEOUT_CYCLES=8): slave never responds -> wbm0_err_o pulses one cycle at the 8th stalled cycle; with the macro undefined, no err occurs after 1000 cycles.
REQ-038 Stray response: wbs_ack_i=1 in IDLE -> both wbmN_ack_o remain 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter slice.
package wb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int DEF_ADDR_WIDTH = 23;
    localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/wb_arb_timeout.sv
// Bus watchdog: counts stalled strobes of the current owner and fires an
// error pulse when the count reaches TIMEOUT_CYCLES.
module wb_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic busy,
    input  logic active,
    input  logic stb,
    input  logic resp,
    output logic fire
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] count_q;

    assign fire = busy & active & (count_q == LIMIT);

    // Any response, the error pulse itself or losing the bus restarts the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (!busy || !active || resp || fire) begin
            count_q <= '0;
        end else if (stb) begin
            count_q <= count_q + 16'd1;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone classic arbiter in front of one slave.
// Optional bus watchdog enabled by defining WB_ARBITER_TIMEOUT_EN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wbm0_cyc_i,
    input  logic                  wbm0_stb_i,
    input  logic                  wbm0_we_i,
    input  logic [ADDR_WIDTH-1:0] wbm0_adr_i,
    input  logic [DATA_WIDTH-1:0] wbm0_dat_i,
    output logic                  wbm0_ack_o,
    output logic                  wbm0_err_o,
    output logic                  wbm0_rty_o,
    output logic [DATA_WIDTH-1:0] wbm0_dat_o,
    input  logic                  wbm1_cyc_i,
    input  logic                  wbm1_stb_i,
    input  logic                  wbm1_we_i,
    input  logic [ADDR_WIDTH-1:0] wbm1_adr_i,
    input  logic [DATA_WIDTH-1:0] wbm1_dat_i,
    output logic                  wbm1_ack_o,
    output logic                  wbm1_err_o,
    output logic                  wbm1_rty_o,
    output logic [DATA_WIDTH-1:0] wbm1_dat_o,
    output logic                  wbs_cyc_o,
    output logic                  wbs_stb_o,
    output logic                  wbs_we_o,
    output logic [ADDR_WIDTH-1:0] wbs_adr_o,
    output logic [DATA_WIDTH-1:0] wbs_dat_o,
    input  logic                  wbs_ack_i,
    input  logic                  wbs_err_i,
    input  logic                  wbs_rty_i,
    input  logic [DATA_WIDTH-1:0] wbs_dat_i,
    output logic [1:0]            grant_o
);

    arb_state_t state_q;
    logic       owner_q;
    logic       last_q;
    logic       rst_done_q;
    logic       next_owner;
    logic       busy;
    logic       sel_cyc;
    logic       sel_stb;
    logic       to_fire;
    logic       ack_fwd;
    logic       err_fwd;
    logic       rty_fwd;
    logic [DATA_WIDTH-1:0] dat_fwd;

    // On a tie the master that was not served last wins.
    assign next_owner = (wbm0_cyc_i && wbm1_cyc_i) ? ~last_q : wbm1_cyc_i;

    // rst_done_q holds off the first grant until the second edge after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            rst_done_q <= 1'b0;
            grant_o    <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rst_done_q) begin
                        rst_done_q <= 1'b1;
                    end else if (wbm0_cyc_i || wbm1_cyc_i) begin
                        owner_q <= next_owner;
                        grant_o <= next_owner ? 2'b10 : 2'b01;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (!sel_cyc) begin
                        last_q  <= owner_q;
                        grant_o <= 2'b00;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy    = (state_q == BUSY);
    assign sel_cyc = owner_q ? wbm1_cyc_i : wbm0_cyc_i;
    assign sel_stb = owner_q ? wbm1_stb_i : wbm0_stb_i;

    assign wbs_cyc_o = busy & sel_cyc;
    assign wbs_stb_o = wbs_cyc_o & sel_stb & ~to_fire;
    assign wbs_we_o  = busy & (owner_q ? wbm1_we_i : wbm0_we_i);
    assign wbs_adr_o = busy ? (owner_q ? wbm1_adr_i : wbm0_adr_i) : '0;
    assign wbs_dat_o = busy ? (owner_q ? wbm1_dat_i : wbm0_dat_i) : '0;

    // Responses only pass while the slave actually sees a cycle.
    assign ack_fwd = wbs_cyc_o & wbs_ack_i;
    assign err_fwd = (wbs_cyc_o & wbs_err_i) | to_fire;
    assign rty_fwd = wbs_cyc_o & wbs_rty_i;
    assign dat_fwd = wbs_cyc_o ? wbs_dat_i : '0;

    assign wbm0_ack_o = ~owner_q & ack_fwd;
    assign wbm0_err_o = ~owner_q & err_fwd;
    assign wbm0_rty_o = ~owner_q & rty_fwd;
    assign wbm0_dat_o = owner_q ? '0 : dat_fwd;
    assign wbm1_ack_o = owner_q & ack_fwd;
    assign wbm1_err_o = owner_q & err_fwd;
    assign wbm1_rty_o = owner_q & rty_fwd;
    assign wbm1_dat_o = owner_q ? dat_fwd : '0;

`ifdef WB_ARBITER_TIMEOUT_EN
    wb_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .busy  (busy),
        .active(sel_cyc),
        .stb   (sel_stb),
        .resp  (wbs_ack_i | wbs_err_i | wbs_rty_i),
        .fire  (to_fire)
    );
`else
    // Without the watchdog the limit has no effect on the logic.
    assign to_fire = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised and directed bench for wb_arbiter against a behavioural model.
module tb_wb_arbiter;

    localparam int AW = 23;
    localparam int DW = 8;
    localparam int TO = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          m_cyc [2];
    logic          m_stb [2];
    logic          m_we  [2];
    logic [AW-1:0] m_adr [2];
    logic [DW-1:0] m_dat [2];
    logic          s_ack, s_err, s_rty;
    logic [DW-1:0] s_dat;

    logic          wbm0_ack_o, wbm0_err_o, wbm0_rty_o;
    logic [DW-1:0] wbm0_dat_o;
    logic          wbm1_ack_o, wbm1_err_o, wbm1_rty_o;
    logic [DW-1:0] wbm1_dat_o;
    logic          wbs_cyc_o, wbs_stb_o, wbs_we_o;
    logic [AW-1:0] wbs_adr_o;
    logic [DW-1:0] wbs_dat_o;
    logic [1:0]    grant_o;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wbm0_cyc_i(m_cyc[0]), .wbm0_stb_i(m_stb[0]), .wbm0_we_i(m_we[0]),
        .wbm0_adr_i(m_adr[0]), .wbm0_dat_i(m_dat[0]),
        .wbm0_ack_o(wbm0_ack_o), .wbm0_err_o(wbm0_err_o), .wbm0_rty_o(wbm0_rty_o),
        .wbm0_dat_o(wbm0_dat_o),
        .wbm1_cyc_i(m_cyc[1]), .wbm1_stb_i(m_stb[1]), .wbm1_we_i(m_we[1]),
        .wbm1_adr_i(m_adr[1]), .wbm1_dat_i(m_dat[1]),
        .wbm1_ack_o(wbm1_ack_o), .wbm1_err_o(wbm1_err_o), .wbm1_rty_o(wbm1_rty_o),
        .wbm1_dat_o(wbm1_dat_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
        .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty), .wbs_dat_i(s_dat),
        .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: owner -1 means nobody holds the bus.
    int m_owner = -1;
    bit m_last  = 1'b1;
    bit m_ready = 1'b0;
    int m_stall = 0;

    function automatic bit exp_fire();
`ifdef WB_ARBITER_TIMEOUT_EN
        return (m_owner >= 0) && m_cyc[m_owner] && (m_stall == TO);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_owner = -1;
            m_last  = 1'b1;
            m_ready = 1'b0;
            m_stall = 0;
        end else if (m_owner < 0) begin
            m_stall = 0;
            if (!m_ready)                 m_ready = 1'b1;
            else if (m_cyc[0] && m_cyc[1]) m_owner = m_last ? 0 : 1;
            else if (m_cyc[0])            m_owner = 0;
            else if (m_cyc[1])            m_owner = 1;
        end else begin
            if (!m_cyc[m_owner]) begin
                m_last  = (m_owner == 1);
                m_owner = -1;
                m_stall = 0;
            end else if (exp_fire() || s_ack || s_err || s_rty) begin
                m_stall = 0;
            end else if (m_stb[m_owner]) begin
                m_stall = m_stall + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Every cycle, compare all outputs against what the model says they must be.
    always @(negedge clk_i) begin
        logic [63:0] e_grant, e_wbs, e_r0, e_r1;
        logic [63:0] e_resp;
        logic        cyc, fire;
        e_grant = '0; e_wbs = '0; e_r0 = '0; e_r1 = '0; e_resp = '0;
        if (m_owner >= 0) begin
            cyc     = m_cyc[m_owner];
            fire    = exp_fire();
            e_grant = (m_owner == 0) ? 64'd1 : 64'd2;
            e_wbs   = 64'({cyc, cyc & m_stb[m_owner] & ~fire, m_we[m_owner],
                            m_adr[m_owner], m_dat[m_owner]});
            e_resp  = 64'({cyc & s_ack, (cyc & s_err) | fire, cyc & s_rty,
                           cyc ? s_dat : 8'h00});
            if (m_owner == 0) e_r0 = e_resp;
            else              e_r1 = e_resp;
        end
        checkOutput("grant", 64'(grant_o), e_grant);
        checkOutput("slave_bus", 64'({wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o}), e_wbs);
        checkOutput("m0_resp", 64'({wbm0_ack_o, wbm0_err_o, wbm0_rty_o, wbm0_dat_o}), e_r0);
        checkOutput("m1_resp", 64'({wbm1_ack_o, wbm1_err_o, wbm1_rty_o, wbm1_dat_o}), e_r1);
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic applyStimulus(input logic c0, input logic c1);
        m_cyc[0] = c0; m_stb[0] = c0;
        m_cyc[1] = c1; m_stb[1] = c1;
    endtask

    int err_pulses;

    initial begin
        rst_ni = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
            m_adr[i] = '0;   m_dat[i] = '0;
        end
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = '0;
        repeat (3) tick();
        checkOutput("reset_grant", 64'(grant_o), 64'd0);
        checkOutput("reset_wbs_cyc", 64'(wbs_cyc_o), 64'd0);

        // Tie straight out of reset, then round-robin hand-over
        applyStimulus(1'b1, 1'b1);
        rst_ni = 1'b1;
        tick();
        checkOutput("first_edge_no_grant", 64'(grant_o), 64'd0);
        tick();
        checkOutput("tie_m0_first", 64'(grant_o), 64'd1);
        applyStimulus(1'b0, 1'b1);
        tick();
        checkOutput("idle_gap", 64'(grant_o), 64'd0);
        tick();
        checkOutput("rr_m1", 64'(grant_o), 64'd2);
        applyStimulus(1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1);
        tick();
        checkOutput("rr_tie_m0", 64'(grant_o), 64'd1);
        applyStimulus(1'b0, 1'b0);
        repeat (2) tick();

        // Single master read with late ack
        applyStimulus(1'b1, 1'b0);
        m_we[0] = 1'b0; m_adr[0] = 23'h000010;
        tick();
        checkOutput("single_grant", 64'(grant_o), 64'd1);
        checkOutput("single_adr", 64'(wbs_adr_o), 64'h10);
        repeat (2) tick();
        s_ack = 1'b1; s_dat = 8'hA5;
        #1;
        checkOutput("single_ack", 64'(wbm0_ack_o), 64'd1);
        checkOutput("single_dat", 64'(wbm0_dat_o), 64'hA5);
        checkOutput("single_other_ack", 64'(wbm1_ack_o), 64'd0);
        tick();
        s_ack = 1'b0;
        applyStimulus(1'b0, 1'b0);
        repeat (2) tick();

        // Bus lock by m1 across four strobes
        applyStimulus(1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            s_ack = 1'b1;
            #1;
            checkOutput("lock_grant", 64'(grant_o), 64'd2);
            checkOutput("lock_m1_ack", 64'(wbm1_ack_o), 64'd1);
            checkOutput("lock_m0_ack", 64'(wbm0_ack_o), 64'd0);
            tick();
            s_ack = 1'b0;
            tick();
        end
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput("lock_release_idle", 64'(grant_o), 64'd0);
        tick();
        checkOutput("lock_release_m0", 64'(grant_o), 64'd1);
        applyStimulus(1'b0, 1'b0);
        repeat (2) tick();

        // Reset while m1 owns the bus
        applyStimulus(1'b0, 1'b1);
        tick();
        rst_ni = 1'b0;
        s_ack  = 1'b1;
        #1;
        checkOutput("midrst_grant", 64'(grant_o), 64'd0);
        checkOutput("midrst_cyc", 64'(wbs_cyc_o), 64'd0);
        checkOutput("midrst_stb", 64'(wbs_stb_o), 64'd0);
        checkOutput("midrst_m1_ack", 64'(wbm1_ack_o), 64'd0);
        repeat (2) tick();
        s_ack = 1'b0;
        applyStimulus(1'b1, 1'b1);
        rst_ni = 1'b1;
        repeat (2) tick();
        checkOutput("post_reset_tie_m0", 64'(grant_o), 64'd1);
        applyStimulus(1'b0, 1'b0);
        repeat (2) tick();

        // Stray response while idle
        s_ack = 1'b1;
        #1;
        checkOutput("stray_m0_ack", 64'(wbm0_ack_o), 64'd0);
        checkOutput("stray_m1_ack", 64'(wbm1_ack_o), 64'd0);
        tick();
        s_ack = 1'b0;

        // Silent slave: watchdog behaviour
        applyStimulus(1'b1, 1'b0);
        tick();
        err_pulses = 0;
`ifdef WB_ARBITER_TIMEOUT_EN
        for (int k = 0; k < 20; k++) begin
            #1;
            if (wbm0_err_o) err_pulses++;
            tick();
        end
        checkOutput("timeout_pulses", 64'(err_pulses), 64'd2);
`else
        for (int k = 0; k < 1000; k++) begin
            #1;
            if (wbm0_err_o) err_pulses++;
            tick();
        end
        checkOutput("no_timeout_pulses", 64'(err_pulses), 64'd0);
`endif
        applyStimulus(1'b0, 1'b0);
        repeat (2) tick();

        // Random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (m_cyc[i]) begin
                    if ($urandom_range(7) == 0) m_cyc[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    m_cyc[i] = 1'b1;
                end
                m_stb[i] = m_cyc[i] & ($urandom_range(3) != 0);
                m_we[i]  = 1'($urandom);
                m_adr[i] = AW'($urandom);
                m_dat[i] = DW'($urandom);
            end
            s_ack  = ($urandom_range(2) == 0);
            s_err  = ($urandom_range(15) == 0);
            s_rty  = ($urandom_range(15) == 0);
            s_dat  = DW'($urandom);
            rst_ni = ($urandom_range(499) != 0);
            tick();
        end
        rst_ni = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
